// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples bit_clk/frame_clk/data on clk and deserialises
// Philips-framed stereo slots into parallel left/right sample pairs.
module i2s_receiver #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_WIDTH    = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    slot_error
);

  typedef enum logic [0:0] {StSync, StActive} state_e;

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(SAMPLE_WIDTH - 1);

  logic [SYNC_STAGES-1:0] bclk_sync_q, ws_sync_q, data_sync_q;
  logic                   bclk_prev_q;
  logic                   bclk_s, ws_s, d_s, rise;

  state_e                  state_q, state_d;
  logic                    ws_prev_q, ws_prev_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    pending_q, pending_d;
  logic [SAMPLE_WIDTH-1:0] left_d, right_d;
  logic                    valid_d, error_d;
  logic [SAMPLE_WIDTH-1:0] word;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign ws_s   = ws_sync_q[SYNC_STAGES-1];
  assign d_s    = data_sync_q[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_prev_q;

  // Shift register with the current bit written at MSB-first position cnt.
  always_comb begin
    word = shift_q;
    for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
      if (cnt_q == CNT_WIDTH'(SAMPLE_WIDTH - 1 - i)) begin
        word[i] = d_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    left_d    = sample_left;
    right_d   = sample_right;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    if (rise) begin
      ws_prev_d = ws_s;
      unique case (state_q)
        StSync: begin
          if (ws_s != ws_prev_q) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = StActive;
          end
        end
        StActive: begin
          shift_d = word;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (ws_s != ws_prev_q) begin
            cnt_d   = '0;
            shift_d = '0;
            error_d = (cnt_q < LastCnt);
            if (!ws_prev_q) begin
              hold_d    = word;
              pending_d = 1'b1;
            end else if (pending_q) begin
              left_d    = hold_q;
              right_d   = word;
              valid_d   = 1'b1;
              pending_d = 1'b0;
            end
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      ws_sync_q    <= '0;
      data_sync_q  <= '0;
      bclk_prev_q  <= 1'b0;
      state_q      <= StSync;
      ws_prev_q    <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      pending_q    <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      slot_error   <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bit_clk};
      ws_sync_q    <= {ws_sync_q[SYNC_STAGES-2:0], frame_clk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], data};
      bclk_prev_q  <= bclk_s;
      state_q      <= state_d;
      ws_prev_q    <= ws_prev_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      sample_left  <= left_d;
      sample_right <= right_d;
      sample_valid <= valid_d;
      slot_error   <= error_d;
    end
  end

endmodule
